// File: rtl/wb_writeback_stage_pkg.sv
// wb_writeback_stage_pkg: shared write-back source codes, load funct3 codes and register index width
package wb_writeback_stage_pkg;
  localparam int REG_IDX_W = 5;
  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'b00,
    WB_SEL_LOAD = 2'b01,
    WB_SEL_PC4  = 2'b10,
    WB_SEL_RSV  = 2'b11
  } wb_sel_e;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
endpackage

// File: rtl/wb_writeback_stage_if.sv
// wb_writeback_stage_if: MEM-stage fields, register file write port and decode bypass signals
interface wb_writeback_stage_if #(parameter int width = 32);
  import wb_writeback_stage_pkg::*;
  logic                 valid_in;
  logic                 regwrite_in;
  logic [REG_IDX_W-1:0] rd_in;
  logic [1:0]           wb_sel;
  logic [2:0]           funct3;
  logic [1:0]           addr_lo;
  logic [width-1:0]     alu_result;
  logic [width-1:0]     mem_rdata;
  logic [width-1:0]     pc_plus4;
  logic [REG_IDX_W-1:0] Read1;
  logic [REG_IDX_W-1:0] Read2;
  logic [width-1:0]     RFData1;
  logic [width-1:0]     RFData2;
  logic                 Regwrite;
  logic [REG_IDX_W-1:0] WriteReg;
  logic [width-1:0]     Writedata;
  logic [width-1:0]     Data1;
  logic [width-1:0]     Data2;
  modport master (
    output valid_in, regwrite_in, rd_in, wb_sel, funct3, addr_lo, alu_result, mem_rdata, pc_plus4,
    output Read1, Read2, RFData1, RFData2,
    input  Regwrite, WriteReg, Writedata, Data1, Data2
  );
  modport slave (
    input  valid_in, regwrite_in, rd_in, wb_sel, funct3, addr_lo, alu_result, mem_rdata, pc_plus4,
    input  Read1, Read2, RFData1, RFData2,
    output Regwrite, WriteReg, Writedata, Data1, Data2
  );
endinterface

// File: rtl/wb_writeback_stage_load_align.sv
// wb_load_align: shifts the raw memory word by the byte offset and sign/zero-extends per load size
module wb_load_align
  import wb_writeback_stage_pkg::*;
#(
  parameter int width = 32
) (
  input  logic [width-1:0] mem_rdata,
  input  logic [1:0]       addr_lo,
  input  logic [2:0]       funct3,
  output logic [width-1:0] aligned
);
  logic [width-1:0] bsh, hsh;
  assign bsh = mem_rdata >> {addr_lo, 3'b000};
  assign hsh = mem_rdata >> {addr_lo[1], 4'b0000};
  // undefined funct3 codes fall through to the full word
  always_comb
    aligned = funct3 == F3_LB  ? {{(width-8){bsh[7]}}, bsh[7:0]} :
              funct3 == F3_LH  ? {{(width-16){hsh[15]}}, hsh[15:0]} :
              funct3 == F3_LBU ? {{(width-8){1'b0}}, bsh[7:0]} :
              funct3 == F3_LHU ? {{(width-16){1'b0}}, hsh[15:0]} :
              mem_rdata;
endmodule

// File: rtl/wb_writeback_stage.sv
// wb_writeback_stage: MEM/WB register, write-back mux, x0 suppression, decode bypass and retire counter
module wb_writeback_stage
  import wb_writeback_stage_pkg::*;
#(
  parameter int width = 32,
  parameter int CNT_W = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 flush,
  wb_writeback_stage_if.slave  bus,
  output logic [CNT_W-1:0]     instret
);
  logic                 valid_q, regwrite_q;
  logic [REG_IDX_W-1:0] rd_q;
  wb_sel_e              wb_sel_q;
  logic [2:0]           funct3_q;
  logic [1:0]           addr_lo_q;
  logic [width-1:0]     alu_q, mem_q, pc4_q, load_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      wb_sel_q   <= WB_SEL_ALU;
      funct3_q   <= '0;
      addr_lo_q  <= '0;
      alu_q      <= '0;
      mem_q      <= '0;
      pc4_q      <= '0;
    end else if (!stall) begin
      valid_q    <= bus.valid_in & ~flush;
      regwrite_q <= bus.regwrite_in;
      rd_q       <= bus.rd_in;
      wb_sel_q   <= wb_sel_e'(bus.wb_sel);
      funct3_q   <= bus.funct3;
      addr_lo_q  <= bus.addr_lo;
      alu_q      <= bus.alu_result;
      mem_q      <= bus.mem_rdata;
      pc4_q      <= bus.pc_plus4;
    end
  // the retiring instruction leaves the stage on every non-stalled edge
  always_ff @(posedge clk or posedge rst)
    if (rst) instret <= '0;
    else if (valid_q && !stall) instret <= instret + CNT_W'(1);
  wb_load_align #(.width(width)) u_align (
    .mem_rdata (mem_q),
    .addr_lo   (addr_lo_q),
    .funct3    (funct3_q),
    .aligned   (load_data)
  );
  assign bus.Regwrite  = valid_q & regwrite_q & (rd_q != '0);
  assign bus.WriteReg  = rd_q;
  assign bus.Writedata = wb_sel_q == WB_SEL_LOAD ? load_data :
                         wb_sel_q == WB_SEL_PC4  ? pc4_q : alu_q;
  assign bus.Data1 = bus.Read1 == '0 ? '0 :
                     (bus.Regwrite && bus.WriteReg == bus.Read1) ? bus.Writedata : bus.RFData1;
  assign bus.Data2 = bus.Read2 == '0 ? '0 :
                     (bus.Regwrite && bus.WriteReg == bus.Read2) ? bus.Writedata : bus.RFData2;
endmodule

// File: tb/tb_wb_writeback_stage.sv
// tb_wb_writeback_stage: directed vectors plus a behavioural write-back model checked every cycle
module tb_wb_writeback_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stall = 1'b0;
  logic flush = 1'b0;
  logic [63:0] instret;
  logic [3:0]  instret4;
  int total = 0;
  int bad = 0;

  wb_writeback_stage_if #(.width(32)) bus ();
  wb_writeback_stage_if #(.width(32)) bus4 ();

  wb_writeback_stage #(.width(32), .CNT_W(64)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .bus(bus.slave), .instret(instret));
  wb_writeback_stage #(.width(32), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .bus(bus4.slave), .instret(instret4));

  assign bus4.valid_in    = bus.valid_in;
  assign bus4.regwrite_in = bus.regwrite_in;
  assign bus4.rd_in       = bus.rd_in;
  assign bus4.wb_sel      = bus.wb_sel;
  assign bus4.funct3      = bus.funct3;
  assign bus4.addr_lo     = bus.addr_lo;
  assign bus4.alu_result  = bus.alu_result;
  assign bus4.mem_rdata   = bus.mem_rdata;
  assign bus4.pc_plus4    = bus.pc_plus4;
  assign bus4.Read1       = bus.Read1;
  assign bus4.Read2       = bus.Read2;
  assign bus4.RFData1     = bus.RFData1;
  assign bus4.RFData2     = bus.RFData2;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h @%0t", nm, act, exp, $time);
    end
  endtask

  // model: the instruction currently held in the stage, as a plain record
  typedef struct {
    bit         valid;
    bit         rw;
    int         rd;
    int         sel;
    int         f3;
    int         a;
    longint     alu;
    longint     mem;
    longint     pc4;
  } instr_t;
  instr_t m;
  longint m_cnt;

  function automatic logic [31:0] wb_value(input instr_t i);
    longint b, h;
    b = (i.mem / (64'd1 << (8 * i.a))) % 256;
    h = (i.mem / (64'd1 << (16 * (i.a / 2)))) % 65536;
    if (i.sel == 2) return i.pc4[31:0];
    if (i.sel != 1) return i.alu[31:0];
    case (i.f3)
      0:       return 32'(b >= 128 ? b - 256 : b);
      1:       return 32'(h >= 32768 ? h - 65536 : h);
      4:       return 32'(b);
      5:       return 32'(h);
      default: return i.mem[31:0];
    endcase
  endfunction

  always @(posedge clk or posedge rst)
    if (rst) begin
      m = '{default: 0};
      m_cnt = 0;
    end else if (!stall) begin
      if (m.valid) m_cnt++;
      m.valid = bus.valid_in && !flush;
      m.rw  = bus.regwrite_in;
      m.rd  = int'(bus.rd_in);
      m.sel = int'(bus.wb_sel);
      m.f3  = int'(bus.funct3);
      m.a   = int'(bus.addr_lo);
      m.alu = longint'(bus.alu_result);
      m.mem = longint'(bus.mem_rdata);
      m.pc4 = longint'(bus.pc_plus4);
    end

  always @(negedge clk)
    if (!rst) begin
      logic        ewe;
      logic [31:0] ewd;
      ewe = m.valid && m.rw && m.rd != 0;
      ewd = wb_value(m);
      chk("m_regwrite", bus.Regwrite, ewe);
      chk("m_writereg", bus.WriteReg, m.rd);
      chk("m_writedata", bus.Writedata, ewd);
      chk("m_data1", bus.Data1, bus.Read1 == 0 ? 0 : (ewe && m.rd == bus.Read1) ? ewd : bus.RFData1);
      chk("m_data2", bus.Data2, bus.Read2 == 0 ? 0 : (ewe && m.rd == bus.Read2) ? ewd : bus.RFData2);
      chk("m_instret", instret, m_cnt);
      chk("m_instret4", instret4, m_cnt % 16);
    end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [1:0] sel, input logic [31:0] alu);
    bus.valid_in = 1'b1; bus.regwrite_in = 1'b1; bus.rd_in = rd; bus.wb_sel = sel; bus.alu_result = alu;
  endtask

  task automatic load(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] want, input string nm);
    issue(5'd7, 2'b01, 32'h0);
    bus.funct3 = f3; bus.addr_lo = a; bus.mem_rdata = 32'h80F0_7F81;
    step();
    chk(nm, bus.Writedata, want);
  endtask

  initial begin
    logic [63:0] c0;
    logic [31:0] w0;
    bus.valid_in = 0; bus.regwrite_in = 0; bus.rd_in = 0; bus.wb_sel = 0; bus.funct3 = 0;
    bus.addr_lo = 0; bus.alu_result = 0; bus.mem_rdata = 0; bus.pc_plus4 = 0;
    bus.Read1 = 0; bus.Read2 = 0; bus.RFData1 = 0; bus.RFData2 = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_regwrite", bus.Regwrite, 0);
    chk("reset_instret", instret, 0);

    issue(5'd5, 2'b00, 32'h1234);
    step();
    chk("alu_regwrite", bus.Regwrite, 1);
    chk("alu_writereg", bus.WriteReg, 5);
    chk("alu_writedata", bus.Writedata, 32'h1234);
    bus.Read1 = 5; bus.RFData1 = 32'hDEAD_BEEF; bus.Read2 = 6; bus.RFData2 = 32'h6666;
    #1;
    chk("bypass_data1", bus.Data1, 32'h1234);
    chk("nobypass_data2", bus.Data2, 32'h6666);

    load(3'b000, 2'd0, 32'hFFFF_FF81, "lb_a0");
    load(3'b100, 2'd3, 32'h0000_0080, "lbu_a3");
    load(3'b001, 2'd2, 32'hFFFF_80F0, "lh_a2");
    load(3'b101, 2'd0, 32'h0000_7F81, "lhu_a0");
    load(3'b010, 2'd1, 32'h80F0_7F81, "lw_a1");
    for (int f = 0; f < 8; f++)
      for (int a = 0; a < 4; a++) begin
        issue(5'(f + 8), 2'b01, 32'h0);
        bus.funct3 = 3'(f); bus.addr_lo = 2'(a); bus.mem_rdata = 32'h1234_5678 ^ (32'h0101_0101 * f);
        step();
      end

    issue(5'd0, 2'b00, 32'hABCD);
    step();
    chk("x0_regwrite", bus.Regwrite, 0);
    bus.Read1 = 0; bus.RFData1 = 32'h55;
    #1;
    chk("x0_data1", bus.Data1, 0);
    issue(5'd1, 2'b10, 32'h9);
    bus.pc_plus4 = 32'h104;
    step();
    chk("jal_writedata", bus.Writedata, 32'h104);
    issue(5'd2, 2'b11, 32'h7777);
    step();
    chk("rsv_writedata", bus.Writedata, 32'h7777);

    c0 = instret; w0 = bus.Writedata;
    stall = 1'b1;
    issue(5'd9, 2'b00, 32'h9999);
    repeat (3) begin
      step();
      chk("stall_instret", instret, c0);
      chk("stall_writedata", bus.Writedata, w0);
      chk("stall_regwrite", bus.Regwrite, 1);
    end
    flush = 1'b1;
    step();
    chk("stall_flush_held", bus.Writedata, w0);
    stall = 1'b0;
    step();
    chk("flush_regwrite", bus.Regwrite, 0);
    chk("flush_retire_held", instret, c0 + 1);
    step();
    chk("bubble_no_count", instret, c0 + 1);
    flush = 1'b0;
    bus.regwrite_in = 1'b0;
    step();
    chk("norw_regwrite", bus.Regwrite, 0);
    step();
    chk("norw_counted", instret, c0 + 2);

    #2 rst = 1'b1;
    #1;
    chk("async_rst_regwrite", bus.Regwrite, 0);
    chk("async_rst_writereg", bus.WriteReg, 0);
    chk("async_rst_writedata", bus.Writedata, 0);
    chk("async_rst_instret", instret, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      issue(5'(i + 3), 2'b00, 32'(i * 3));
      bus.regwrite_in = 1'(i & 1);
      step();
    end
    bus.valid_in = 1'b0;
    step();
    chk("wrap_instret4", instret4, 1);
    chk("wrap_instret64", instret, 17);
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
